// File: rtl/multimac_scan_engine_if.sv
// Command/status bus of the multimac scan engine: the master issues load/start, the slave reports busy/done/found/result.
interface multimac_scan_engine_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 13,
  parameter int IDX_W  = $clog2(DEPTH)
);
  logic [IDX_W-1:0]        index;
  logic [DATA_W-1:0]       data;
  logic [1:0]              mode;
  logic                    load;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    found;
  logic signed [ACC_W-1:0] result;

  modport master (output index, data, mode, load, start,
                  input  busy, done, found, result);
  modport slave  (input  index, data, mode, load, start,
                  output busy, done, found, result);
endinterface

// File: rtl/multimac_scan_engine.sv
// Multi-mode scan engine (MIN / MAX / MADD double prefix-sum / CLR) over a signed cell memory.
// Define MULTIMAC_SAT_EN for saturating cell and accumulator arithmetic; otherwise it wraps.
module multimac_scan_engine #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int CELL_W = 6,
  parameter int ACC_W  = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multimac_scan_engine_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {MODE_MIN = 2'b00, MODE_MAX = 2'b01, MODE_MADD = 2'b10, MODE_CLR = 2'b11} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

  state_e                   state, state_nxt;
  mode_e                    scan_mode, cmd_mode;
  logic [IDX_W-1:0]         idx, prev_index;
  logic signed [ACC_W-1:0]  delta, count, total;
  logic signed [ACC_W-1:0]  delta_nxt, count_nxt, total_nxt;
  logic signed [CELL_W-1:0] mem [DEPTH];
  logic                     start_ok, load_ok, last_cell, hit, found_q;
  logic signed [ACC_W-1:0]  result_q;

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
`ifdef MULTIMAC_SAT_EN
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  // Adds (sub=0) or subtracts (sub=1) the unsigned load operand from a cell.
  function automatic logic signed [CELL_W-1:0] cell_upd(input logic signed [CELL_W-1:0] c,
                                                       input logic [DATA_W-1:0] d,
                                                       input logic sub);
`ifdef MULTIMAC_SAT_EN
    logic signed [CELL_W:0] s, dx;
    dx = {{(CELL_W+1-DATA_W){1'b0}}, d};
    s  = sub ? {c[CELL_W-1], c} - dx : {c[CELL_W-1], c} + dx;
    if (s[CELL_W] != s[CELL_W-1])
      return s[CELL_W] ? {1'b1, {(CELL_W-1){1'b0}}} : {1'b0, {(CELL_W-1){1'b1}}};
    return s[CELL_W-1:0];
`else
    logic signed [CELL_W-1:0] dx;
    dx = {{(CELL_W-DATA_W){1'b0}}, d};
    return sub ? c - dx : c + dx;
`endif
  endfunction

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    cmd_mode   = mode_e'(bus.mode);
    prev_index = bus.index - IDX_W'(1);
    start_ok   = (state == S_IDLE) && bus.start;
    load_ok    = (state == S_IDLE) && bus.load && !bus.start && (cmd_mode != MODE_CLR);
    last_cell  = (scan_mode == MODE_MIN) ? (idx == IDX_W'(DEPTH-1)) : (idx == '0);
    hit        = ((scan_mode == MODE_MIN) || (scan_mode == MODE_MAX)) && (mem[idx] != '0);
    delta_nxt  = acc_add(delta, {{(ACC_W-CELL_W){mem[idx][CELL_W-1]}}, mem[idx]});
    count_nxt  = acc_add(count, delta_nxt);
    total_nxt  = acc_add(total, count_nxt);
    state_nxt  = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_SCAN;
      S_SCAN:  if (hit || last_cell) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_mode <= MODE_MIN;
      idx       <= '0;
      delta     <= '0;
      count     <= '0;
      total     <= '0;
      found_q   <= 1'b0;
      result_q  <= '0;
    end else if (start_ok) begin
      scan_mode <= cmd_mode;
      idx       <= (cmd_mode == MODE_MIN) ? '0 : IDX_W'(DEPTH-1);
      delta     <= '0;
      count     <= '0;
      total     <= '0;
      found_q   <= 1'b0;
      result_q  <= '0;
    end else if (state == S_SCAN) begin
      unique case (scan_mode)
        MODE_MIN, MODE_MAX: begin
          if (hit) begin
            result_q <= ACC_W'(idx);
            found_q  <= 1'b1;
          end else if (!last_cell) begin
            idx <= (scan_mode == MODE_MIN) ? idx + IDX_W'(1) : idx - IDX_W'(1);
          end
        end
        MODE_MADD: begin
          delta <= delta_nxt;
          count <= count_nxt;
          total <= total_nxt;
          if (last_cell) result_q <= total_nxt;
          else           idx      <= idx - IDX_W'(1);
        end
        MODE_CLR: if (!last_cell) idx <= idx - IDX_W'(1);
      endcase
    end
  end

  // NOTE: the cell memory is deliberately not reset; software clears it with a CLR scan.
  always_ff @(posedge clk) begin
    if (load_ok && cmd_mode == MODE_MADD) begin
      mem[bus.index] <= cell_upd(mem[bus.index], bus.data, 1'b0);
      if (bus.index != '0) mem[prev_index] <= cell_upd(mem[prev_index], bus.data, 1'b1);
    end else if (load_ok) begin
      mem[bus.index] <= CELL_W'(1);
    end else if (state == S_SCAN && scan_mode == MODE_CLR) begin
      mem[idx] <= '0;
    end
  end

  assign bus.busy   = (state == S_SCAN);
  assign bus.done   = (state == S_DONE);
  assign bus.found  = found_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_multimac_scan_engine.sv
// Directed plus randomized bench for multimac_scan_engine against an integer reference model.
module tb_multimac_scan_engine;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 4;
  localparam int CELL_W = 6;
  localparam int ACC_W  = 13;
  localparam int IDX_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;
  int   mm [DEPTH];

  multimac_scan_engine_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  multimac_scan_engine #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CELL_W(CELL_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Bring an integer into the w-bit signed range: clamp when saturating, else wrap.
  function automatic int fix(input int v, input int w);
    int lo, hi, span, r;
    lo = -(1 << (w-1));
    hi = (1 << (w-1)) - 1;
`ifdef MULTIMAC_SAT_EN
    span = 0;
    r = (v < lo) ? lo : (v > hi) ? hi : v;
`else
    span = 1 << w;
    r = v % span;
    if (r < lo) r += span;
    if (r > hi) r -= span;
`endif
    return r;
  endfunction

  function automatic void model_load(input int m, input int idx, input int d);
    if (m == 0 || m == 1) mm[idx] = 1;
    else if (m == 2) begin
      mm[idx] = fix(mm[idx] + d, CELL_W);
      if (idx > 0) mm[idx-1] = fix(mm[idx-1] - d, CELL_W);
    end
  endfunction

  // Expected found/result and number of edges after the start edge until done is visible.
  function automatic void model_scan(input int m, output int ef, output int er, output int el);
    int d, c, t;
    ef = 0; er = 0; el = DEPTH;
    case (m)
      0: for (int k = DEPTH-1; k >= 0; k--) if (mm[k] != 0) begin ef = 1; er = k; el = k + 1; end
      1: for (int k = 0; k < DEPTH; k++)   if (mm[k] != 0) begin ef = 1; er = k; el = DEPTH - k; end
      2: begin
        d = 0; c = 0; t = 0;
        for (int k = DEPTH-1; k >= 0; k--) begin
          d = fix(d + mm[k], ACC_W);
          c = fix(c + d, ACC_W);
          t = fix(t + c, ACC_W);
        end
        er = t;
      end
      default: for (int k = 0; k < DEPTH; k++) mm[k] = 0;
    endcase
  endfunction

  task automatic do_load(input int m, input int idx, input int d);
    bus.mode  = 2'(m);
    bus.index = IDX_W'(idx);
    bus.data  = DATA_W'(d);
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    model_load(m, idx, d);
  endtask

  // Entered and left at a falling edge. with_load raises load together with start;
  // poke fires start/load while busy and start again in the DONE cycle.
  task automatic run_scan(input int m, input bit with_load, input bit poke, input string tag);
    int ef, er, el, lat;
    model_scan(m, ef, er, el);
    bus.mode  = 2'(m);
    bus.start = 1'b1;
    bus.load  = with_load;
    bus.index = IDX_W'(7);
    bus.data  = DATA_W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    bus.load  = 1'b0;
    check({tag, ":busy_at_start"}, bus.busy, 1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 3) begin bus.start = 1'b1; bus.mode = 2'b01; end
      if (poke && lat == 4) begin bus.start = 1'b0; bus.load = 1'b1; bus.mode = 2'b00; bus.index = IDX_W'(9); end
      if (poke && lat == 5) bus.load = 1'b0;
    end
    check({tag, ":latency"}, lat, el);
    check({tag, ":found"}, bus.found, ef);
    check({tag, ":result"}, bus.result, er);
    check({tag, ":busy_at_done"}, bus.busy, 0);
    if (poke) begin bus.start = 1'b1; bus.mode = 2'b00; end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ":done_pulse"}, bus.done, 0);
    check({tag, ":idle_after"}, bus.busy, 0);
  endtask

  initial begin
    int nl, dones;
    bus.index = '0; bus.data = '0; bus.mode = '0; bus.load = 1'b0; bus.start = 1'b0;
    for (int k = 0; k < DEPTH; k++) mm[k] = 0;

    repeat (2) @(negedge clk);
    check("reset:busy", bus.busy, 0);
    check("reset:done", bus.done, 0);
    check("reset:found", bus.found, 0);
    check("reset:result", bus.result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(3, 0, 0, "clr0");
    run_scan(0, 0, 0, "min_empty");

    do_load(0, 5, 0);
    do_load(0, 11, 0);
    run_scan(0, 0, 0, "min_5_11");
    run_scan(1, 0, 0, "max_5_11");

    run_scan(3, 0, 0, "clr1");
    do_load(2, 3, 2);
    run_scan(2, 0, 0, "madd_pulse");

    run_scan(3, 0, 0, "clr2");
    do_load(2, 0, 7);
    run_scan(2, 0, 0, "madd_idx0");
    run_scan(1, 0, 0, "max_no_wrap");

    run_scan(3, 0, 0, "clr3");
    repeat (3) do_load(2, 5, 15);
    run_scan(2, 0, 0, "madd_overflow");
    run_scan(0, 0, 0, "min_overflow");

    run_scan(3, 0, 0, "clr4");
    run_scan(0, 1, 0, "start_load_together");
    run_scan(2, 0, 1, "poke_busy");
    run_scan(0, 0, 0, "after_poke");

    // Abort a MADD scan with reset just before its eighth cell edge.
    do_load(2, 6, 9);
    do_load(2, 12, 4);
    bus.mode = 2'b10; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort:busy", bus.busy, 0);
    check("abort:done", bus.done, 0);
    check("abort:result", bus.result, 0);
    check("abort:found", bus.found, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
    check("abort:no_done", dones, 0);
    run_scan(2, 0, 0, "madd_retained");

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) run_scan(3, 0, 0, $sformatf("rnd%0d_clr", it));
      nl = $urandom_range(0, 5);
      for (int j = 0; j < nl; j++)
        do_load($urandom_range(0, 3), $urandom_range(0, DEPTH-1), $urandom_range(0, 15));
      run_scan($urandom_range(0, 3), 0, 0, $sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
